// File: rtl/tap_tms_sequencer.sv
// JTAG TAP driver: turns RESET / GOTO_IDLE / SCAN_IR / SCAN_DR commands into
// registered TMS/TDI sequences while tracking the 16-state TAP controller.
module tap_tms_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic                      GCLK_Pad,
    input  logic                      TRST_Pad,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [$clog2(DATA_W)-1:0] cmd_len,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic                      tms_out,
    output logic                      tdi_out,
    input  logic                      tdo_in,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [3:0]                state_obs
);

    localparam int LEN_W = $clog2(DATA_W);
    localparam int CNT_W = LEN_W + 3;

    localparam logic [1:0] OP_RESET     = 2'b00;
    localparam logic [1:0] OP_GOTO_IDLE = 2'b01;
    localparam logic [1:0] OP_SCAN_IR   = 2'b10;
    localparam logic [1:0] OP_SCAN_DR   = 2'b11;

    localparam logic [3:0] TAP_TLR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } ctl_t;

    ctl_t              r_ctl;
    logic [3:0]        r_tap;
    logic              r_tms;
    logic              r_tdi;
    logic              r_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_op;
    logic              r_from_tlr;
    logic [CNT_W-1:0]  r_l;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_idx;
    logic              r_shift;
    logic [LEN_W-1:0]  r_sidx;

    logic [1:0]        w_op;
    logic              w_tlr;
    logic [CNT_W-1:0]  w_l;
    logic [CNT_W-1:0]  w_k;
    logic [CNT_W-1:0]  w_pre;
    logic [CNT_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_kb;
    logic [CNT_W-1:0]  w_len;
    logic              w_tms;
    logic              w_shift;
    logic [LEN_W-1:0]  w_sidx;
    logic [3:0]        w_tap_nxt;

    // IEEE 1149.1 TAP next-state table in the standard 4-bit encoding
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        logic [3:0] n;
        case (s)
            4'hF:    n = tms ? 4'hF : 4'hC;
            4'hC:    n = tms ? 4'h7 : 4'hC;
            4'h7:    n = tms ? 4'h4 : 4'h6;
            4'h6:    n = tms ? 4'h1 : 4'h2;
            4'h2:    n = tms ? 4'h1 : 4'h2;
            4'h1:    n = tms ? 4'h5 : 4'h3;
            4'h3:    n = tms ? 4'h0 : 4'h3;
            4'h0:    n = tms ? 4'h5 : 4'h2;
            4'h5:    n = tms ? 4'h7 : 4'hC;
            4'h4:    n = tms ? 4'hF : 4'hE;
            4'hE:    n = tms ? 4'h9 : 4'hA;
            4'hA:    n = tms ? 4'h9 : 4'hA;
            4'h9:    n = tms ? 4'hD : 4'hB;
            4'hB:    n = tms ? 4'h8 : 4'hB;
            4'h8:    n = tms ? 4'hD : 4'hA;
            4'hD:    n = tms ? 4'h7 : 4'hC;
            default: n = TAP_TLR;
        endcase
        return n;
    endfunction

    assign w_tap_nxt = tap_next(r_tap, r_tms);

    // Sequence length and TMS/TDI-shift info for step w_k; in IDLE this
    // describes step 0 of the command being offered, otherwise the next step
    always_comb begin
        if (r_ctl == ST_IDLE) begin
            w_op  = cmd_op;
            w_tlr = (r_tap == TAP_TLR);
            w_l   = (cmd_len == '0) ? CNT_W'(DATA_W) : CNT_W'(cmd_len);
            w_k   = '0;
        end else begin
            w_op  = r_op;
            w_tlr = r_from_tlr;
            w_l   = r_l;
            w_k   = r_idx + CNT_W'(1);
        end
        w_pre   = (w_tlr && (w_op != OP_RESET)) ? CNT_W'(1) : CNT_W'(0);
        w_head  = (w_op == OP_SCAN_IR) ? CNT_W'(4) : CNT_W'(3);
        w_kb    = w_k - w_pre;
        w_len   = '0;
        w_tms   = 1'b0;
        w_shift = 1'b0;
        w_sidx  = '0;
        case (w_op)
            OP_RESET: begin
                w_len = CNT_W'(5);
                w_tms = 1'b1;
            end
            OP_GOTO_IDLE: begin
                w_len = w_pre;
                w_tms = 1'b0;
            end
            OP_SCAN_IR, OP_SCAN_DR: begin
                w_len = w_pre + w_head + w_l + CNT_W'(2);
                if (w_k < w_pre) begin
                    w_tms = 1'b0;
                end else if (w_kb < w_head) begin
                    w_tms = (w_op == OP_SCAN_IR) ? (w_kb < CNT_W'(2)) : (w_kb == CNT_W'(0));
                end else if (w_kb < w_head + w_l) begin
                    // last shift step carries TMS=1 to leave Shift-xR
                    w_shift = 1'b1;
                    w_sidx  = LEN_W'(w_kb - w_head);
                    w_tms   = (w_kb == w_head + w_l - CNT_W'(1));
                end else begin
                    w_tms = (w_kb == w_head + w_l);
                end
            end
            default: begin
                w_len = '0;
                w_tms = 1'b0;
            end
        endcase
    end

    // Controller FSM, TAP tracker and all registered outputs
    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            r_ctl       <= ST_IDLE;
            r_tap       <= TAP_TLR;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_op        <= OP_RESET;
            r_from_tlr  <= 1'b0;
            r_l         <= '0;
            r_data      <= '0;
            r_idx       <= '0;
            r_shift     <= 1'b0;
            r_sidx      <= '0;
        end else begin
            r_tap <= w_tap_nxt;
            case (r_ctl)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (cmd_valid && r_ready) begin
                        r_op       <= cmd_op;
                        r_from_tlr <= w_tlr;
                        r_l        <= w_l;
                        r_data     <= cmd_data;
                        r_idx      <= '0;
                        r_rsp_data <= '0;
                        r_ready    <= 1'b0;
                        if (w_len == '0) begin
                            r_ctl       <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_tms       <= (w_tap_nxt == TAP_TLR);
                            r_tdi       <= 1'b0;
                            r_shift     <= 1'b0;
                        end else begin
                            r_ctl   <= ST_RUN;
                            r_tms   <= w_tms;
                            r_tdi   <= w_shift ? cmd_data[w_sidx] : 1'b0;
                            r_shift <= w_shift;
                            r_sidx  <= w_sidx;
                        end
                    end else begin
                        r_tms <= (w_tap_nxt == TAP_TLR);
                        r_tdi <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_shift) begin
                        r_rsp_data[r_sidx] <= tdo_in;
                    end
                    if (r_idx == w_len - CNT_W'(1)) begin
                        r_ctl       <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_tms       <= (w_tap_nxt == TAP_TLR);
                        r_tdi       <= 1'b0;
                        r_shift     <= 1'b0;
                    end else begin
                        r_idx   <= w_k;
                        r_tms   <= w_tms;
                        r_tdi   <= w_shift ? r_data[w_sidx] : 1'b0;
                        r_shift <= w_shift;
                        r_sidx  <= w_sidx;
                    end
                end
                ST_DONE: begin
                    r_ctl       <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_tms       <= (w_tap_nxt == TAP_TLR);
                    r_tdi       <= 1'b0;
                end
                default: begin
                    r_ctl       <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_tms       <= (w_tap_nxt == TAP_TLR);
                    r_tdi       <= 1'b0;
                    r_shift     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign tms_out   = r_tms;
    assign tdi_out   = r_tdi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign state_obs = r_tap;

endmodule
